prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Stream-in / program-memory-out bus of the program loader.
// The loader connects through the slave modport; the byte source and memory model use master.
interface prog_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_write
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: length byte N, N data bytes written to program memory, then CPU reset release.
// Define PROG_LOADER_CSUM_EN to require a trailing modulo-256 checksum byte before release.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_,
    prog_loader_if.slave bus,
    output logic         cpu_rst_,
    output logic         done,
    output logic         err
);

    localparam int          CNT_W    = ADDR_W + 1;
    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
`ifdef PROG_LOADER_CSUM_EN
        CSUM = 3'd2,
`endif
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, len_q, cnt_inc;
    logic [31:0]      n_ext;
    logic             ready, accept, len_ok, last_byte, run_q;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]       sum_q;
`endif

    // Counter is one bit wider than the address so a full load never wraps.
    assign ready     = !rst_ && (state_q != RUN) && (state_q != ERR);
    assign accept    = bus.in_valid && ready;
    assign n_ext     = 32'(bus.in_data);
    assign len_ok    = (n_ext != 32'd0) && (n_ext <= CAPACITY);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_byte = (cnt_inc == len_q);

    assign bus.in_ready = ready;
    assign cpu_rst_     = run_q;
    assign done         = run_q;
    assign err          = (state_q == ERR);

    // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_) state_q <= LEN;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            LEN: begin
                if (accept) state_d = len_ok ? DATA : ERR;
            end
            DATA: begin
                if (accept && last_byte) begin
`ifdef PROG_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            CSUM: begin
                if (accept) state_d = (8'(bus.in_data) == sum_q) ? RUN : ERR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // Write port is registered: the strobe follows the accepting cycle by one clock.
    always_ff @(posedge clk) begin
        if (rst_) begin
            cnt_q         <= '0;
            len_q         <= '0;
            run_q         <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef PROG_LOADER_CSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            bus.mem_write <= 1'b0;
            if (state_q == LEN && accept) begin
                cnt_q <= '0;
                len_q <= CNT_W'(bus.in_data);
            end
            if (state_q == DATA && accept) begin
                bus.mem_write <= 1'b1;
                bus.mem_addr  <= cnt_q[ADDR_W-1:0];
                bus.mem_wdata <= bus.in_data;
                cnt_q         <= cnt_inc;
`ifdef PROG_LOADER_CSUM_EN
                sum_q         <= sum_q + 8'(bus.in_data);
`endif
            end
            // Release one cycle after RUN entry so the final write lands first.
            if (state_q == RUN) run_q <= 1'b1;
        end
    end

endmodule
